regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the RISC-V M-extension core. It replaces the fixed 2-read/1-write file with N registered read ports, M write ports and write-to-read bypass. It also carries a per-register busy scoreboard, so long-latency mul/div results can be tracked from issue to writeback. It sits between decode (read) and the writeback arbiter (write/clear).

---
 rtl/riscv_pkg.sv | 13 +
 rtl/regfile_wr_arb.sv | 30 +++
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared integer-core types and defaults for the register file slice.
// Pure declarations; no logic, no latency.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef logic [AW_DEFAULT-1:0] reg_addr_t;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_wr_arb.sv
// Resolves NWR write ports into per-register enable/data, highest port index wins, x0 dropped.
// Purely combinational (zero latency); no handshake, every port is evaluated each cycle.
module regfile_wr_arb
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic [NWR*AW-1:0]     rd,
    input  logic [NWR-1:0]        rd_wd_en,
    input  logic [NWR*XLEN-1:0]   rD,
    output logic [NREGS-1:0]      wr_en,
    output logic [NREGS*XLEN-1:0] wr_dat
);

    always_comb begin
        wr_en  = '0;
        wr_dat = '0;
        // Ascending scan: a later (higher) port overwrites an earlier one to the same register.
        for (int j = 0; j < NWR; j++) begin
            if (rd_wd_en[j] && (rd[j*AW +: AW] != AW'(REG_ZERO))) begin
                wr_en[rd[j*AW +: AW]]                 = 1'b1;
                wr_dat[rd[j*AW +: AW]*XLEN +: XLEN] = rD[j*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass and per-register busy scoreboard.
// Reads are registered (1 cycle) and hold when not enabled; no backpressure, inputs sampled every edge.
module regfile_mp
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rs,
    input  logic [NRD-1:0]      rs_rd_en,
    output logic [NRD*XLEN-1:0] rS,
    output logic [NRD-1:0]      rS_busy,
    input  logic [NWR*AW-1:0]   rd,
    input  logic [NWR-1:0]      rd_wd_en,
    input  logic [NWR*XLEN-1:0] rD,
    input  logic                busy_set_en,
    input  logic [AW-1:0]       busy_set_addr,
    output logic [NREGS-1:0]    busy
);

    logic [NREGS-1:0]      wr_en;
    logic [NREGS*XLEN-1:0] wr_dat;

    logic [XLEN-1:0]     regs_q [NREGS];
    logic [XLEN-1:0]     regs_d [NREGS];
    logic [NREGS-1:0]    busy_q, busy_d;
    logic [NRD*XLEN-1:0] rS_q, rS_d;
    logic [NRD-1:0]      rS_busy_q, rS_busy_d;

    regfile_wr_arb #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_wr_arb (
        .rd       (rd),
        .rd_wd_en (rd_wd_en),
        .rD       (rD),
        .wr_en    (wr_en),
        .wr_dat   (wr_dat)
    );

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int k = 0; k < NREGS; k++) begin
            if (wr_en[k]) begin
                regs_d[k] = wr_dat[k*XLEN +: XLEN];
                busy_d[k] = 1'b0;
            end
            // Set after clear: a newly issued op supersedes the one writing back now.
            if (busy_set_en && (busy_set_addr == AW'(k))) begin
                busy_d[k] = 1'b1;
            end
        end
        regs_d[REG_ZERO] = '0;
        busy_d[REG_ZERO] = 1'b0;
    end

    // Reads look at next-state storage, which gives same-cycle bypass of writes and busy updates.
    always_comb begin
        rS_d      = rS_q;
        rS_busy_d = rS_busy_q;
        for (int i = 0; i < NRD; i++) begin
            if (rs_rd_en[i]) begin
                rS_d[i*XLEN +: XLEN] = regs_d[rs[i*AW +: AW]];
                rS_busy_d[i]         = busy_d[rs[i*AW +: AW]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= '0;
            end
            busy_q    <= '0;
            rS_q      <= '0;
            rS_busy_q <= '0;
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
            busy_q    <= busy_d;
            rS_q      <= rS_d;
            rS_busy_q <= rS_busy_d;
        end
    end

    assign rS      = rS_q;
    assign rS_busy = rS_busy_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector table for the corner cases, then random traffic against an array-based reference model.
module tb_regfile_mp;
    import riscv_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk;
    logic            rst_n;
    logic [2*AW-1:0] rs_addr;
    logic [1:0]      rs_en;
    logic [63:0]     rs_dat;
    logic [1:0]      rs_bsy;
    logic [2*AW-1:0] rd_addr;
    logic [1:0]      rd_en;
    logic [63:0]     rd_dat;
    logic            bs_en;
    logic [AW-1:0]   bs_addr;
    logic [31:0]     busy_vec;

    int checks;
    int failures;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs            (rs_addr),
        .rs_rd_en      (rs_en),
        .rS            (rs_dat),
        .rS_busy       (rs_bsy),
        .rd            (rd_addr),
        .rd_wd_en      (rd_en),
        .rD            (rd_dat),
        .busy_set_en   (bs_en),
        .busy_set_addr (bs_addr),
        .busy          (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural state as plain arrays.
    logic [31:0] m_reg [32];
    logic        m_busy [32];
    logic [31:0] m_rs [2];
    logic        m_rsb [2];

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v;
        for (int k = 0; k < 32; k++) v[k] = m_busy[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            m_reg[k]  = '0;
            m_busy[k] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            m_rs[i]  = '0;
            m_rsb[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int a;
        for (int j = 0; j < 2; j++) begin
            a = int'(rd_addr[j*AW +: AW]);
            if (rd_en[j] && a != 0) begin
                m_reg[a]  = rd_dat[j*32 +: 32];
                m_busy[a] = 1'b0;
            end
        end
        if (bs_en && bs_addr != 0) m_busy[bs_addr] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a = int'(rs_addr[i*AW +: AW]);
            if (rs_en[i]) begin
                m_rs[i]  = m_reg[a];
                m_rsb[i] = m_busy[a];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] re,
                         input logic [4:0] w0, input logic [4:0] w1, input logic [1:0] we,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic be, input logic [4:0] ba);
        rs_addr = {r1, r0};
        rs_en   = re;
        rd_addr = {w1, w0};
        rd_en   = we;
        rd_dat  = {d1, d0};
        bs_en   = be;
        bs_addr = ba;
    endtask

    typedef struct {
        logic [4:0]  r0, r1;
        logic [1:0]  re;
        logic [4:0]  w0, w1;
        logic [1:0]  we;
        logic [31:0] d0, d1;
        logic        be;
        logic [4:0]  ba;
        logic [31:0] e0, e1;
        logic        eb0, eb1;
        logic [31:0] ebusy;
    } vec_t;

    vec_t vt [13];

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();

        //            r0 r1 re  w0 w1 we  d0            d1        be ba  e0         e1       eb0 eb1 ebusy
        vt[0]  = '{5'd0, 5'd0, 2'b00, 5'd3, 5'd0, 2'b01, 32'h15, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{5'd3, 5'd2, 2'b11, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 32'h15, 32'h0, 1'b0, 1'b0, 32'h0};
        vt[2]  = '{5'd0, 5'd0, 2'b01, 5'd0, 5'd0, 2'b01, 32'hFFFFFFFF, 32'h0, 1'b1, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        vt[3]  = '{5'd5, 5'd0, 2'b01, 5'd5, 5'd5, 2'b11, 32'hAAAA, 32'h5555, 1'b0, 5'd0, 32'h5555, 32'h0, 1'b0, 1'b0, 32'h0};
        vt[4]  = '{5'd0, 5'd5, 2'b10, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 32'h5555, 32'h5555, 1'b0, 1'b0, 32'h0};
        vt[5]  = '{5'd7, 5'd0, 2'b01, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b1, 5'd7, 32'h0, 32'h5555, 1'b1, 1'b0, 32'h80};
        vt[6]  = '{5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h5555, 1'b1, 1'b0, 32'h80};
        vt[7]  = '{5'd0, 5'd0, 2'b00, 5'd0, 5'd7, 2'b10, 32'h0, 32'h77, 1'b0, 5'd0, 32'h0, 32'h5555, 1'b1, 1'b0, 32'h0};
        vt[8]  = '{5'd7, 5'd0, 2'b01, 5'd7, 5'd0, 2'b01, 32'h88, 32'h0, 1'b1, 5'd7, 32'h88, 32'h5555, 1'b1, 1'b0, 32'h80};
        vt[9]  = '{5'd3, 5'd0, 2'b01, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 32'h15, 32'h5555, 1'b0, 1'b0, 32'h80};
        vt[10] = '{5'd3, 5'd0, 2'b00, 5'd3, 5'd0, 2'b01, 32'h99, 32'h0, 1'b0, 5'd0, 32'h15, 32'h5555, 1'b0, 1'b0, 32'h80};
        vt[11] = '{5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 32'h15, 32'h5555, 1'b0, 1'b0, 32'h80};
        vt[12] = '{5'd3, 5'd0, 2'b01, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 32'h99, 32'h5555, 1'b0, 1'b0, 32'h80};

        #2;
        check("reset_rS", {32'h0, rs_dat}, 64'h0);
        check("reset_rS_busy", {62'h0, rs_bsy}, 64'h0);
        check("reset_busy", {32'h0, busy_vec}, 64'h0);
        step();
        step();
        rst_n = 1'b1;

        for (int n = 0; n < 13; n++) begin
            drive(vt[n].r0, vt[n].r1, vt[n].re, vt[n].w0, vt[n].w1, vt[n].we,
                  vt[n].d0, vt[n].d1, vt[n].be, vt[n].ba);
            step();
            check($sformatf("vec%0d_rS0", n), {32'h0, rs_dat[31:0]}, {32'h0, vt[n].e0});
            check($sformatf("vec%0d_rS1", n), {32'h0, rs_dat[63:32]}, {32'h0, vt[n].e1});
            check($sformatf("vec%0d_rS_busy", n), {62'h0, rs_bsy}, {62'h0, vt[n].eb1, vt[n].eb0});
            check($sformatf("vec%0d_busy", n), {32'h0, busy_vec}, {32'h0, vt[n].ebusy});
        end

        // Random traffic; narrow address range in half the cycles forces collisions and bypass hits.
        for (int n = 0; n < 400; n++) begin
            int hi;
            hi = ($urandom_range(0, 1) == 1) ? 7 : 31;
            drive(5'($urandom_range(0, hi)), 5'($urandom_range(0, hi)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, hi)), 5'($urandom_range(0, hi)), 2'($urandom_range(0, 3)),
                  $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, hi)));
            step();
            check("rand_rS", rs_dat, {m_rs[1], m_rs[0]});
            check("rand_rS_busy", {62'h0, rs_bsy}, {62'h0, m_rsb[1], m_rsb[0]});
            check("rand_busy", {32'h0, busy_vec}, {32'h0, m_busy_vec()});
        end

        // Asynchronous reset mid-run after a live write of x3.
        drive(5'd3, 5'd3, 2'b11, 5'd3, 5'd0, 2'b01, 32'h15, 32'h0, 1'b1, 5'd3);
        step();
        check("pre_reset_rS0", {32'h0, rs_dat[31:0]}, 64'h15);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_rS", rs_dat, 64'h0);
        check("async_reset_busy", {32'h0, busy_vec}, 64'h0);
        check("async_reset_rS_busy", {62'h0, rs_bsy}, 64'h0);
        step();
        step();
        rst_n = 1'b1;
        drive(5'd3, 5'd0, 2'b01, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0);
        step();
        check("post_reset_x3", {32'h0, rs_dat[31:0]}, 64'h0);
        check("post_reset_x3_model", {32'h0, rs_dat[31:0]}, {32'h0, m_rs[0]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
